seq_bit_packer: RTL

- Downstream consumer of the single-bit sequential-gate stage.
- Collects the 1-bit `out` stream, LSB-first, into NBITS-wide words.
- Presents each completed word on a latency-insensitive val/rdy output interface.
- Backpressures the bit stream through in_rdy when the output register cannot drain.

---
 rtl/seq_bit_packer.sv | 74 +++++++
 1 files changed

// File: rtl/seq_bit_packer.sv
// Serial-to-parallel packer: gathers an LSB-first bit stream into NBITS-wide words on a val/rdy output.
// Optional feature macro: SEQ_BIT_PACKER_PARITY_EN adds a registered even-parity output out_par.
module seq_bit_packer #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic             in_bit,
    output logic             out_val,
    input  logic             out_rdy,
`ifdef SEQ_BIT_PACKER_PARITY_EN
    output logic [NBITS-1:0] out_msg,
    output logic             out_par
`else
    output logic [NBITS-1:0] out_msg
`endif
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    logic [NBITS-1:0] shift;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             complete;
    logic             drain;
    logic [NBITS-1:0] word_next;

    // Only the closing bit of a word can stall; it waits for a free output register.
    assign in_rdy    = (cnt != LAST) || !out_val || out_rdy;
    assign accept    = in_val && in_rdy;
    assign complete  = accept && (cnt == LAST);
    assign drain     = out_val && out_rdy;
    assign word_next = {in_bit, shift[NBITS-2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            shift <= '0;
        end else if (complete) begin
            cnt   <= '0;
            shift <= '0;
        end else if (accept) begin
            shift[cnt] <= in_bit;
            cnt        <= cnt + 1'b1;
        end
    end

    // A completion on the same edge as a drain reloads the register without a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val <= 1'b0;
            out_msg <= '0;
        end else if (complete) begin
            out_val <= 1'b1;
            out_msg <= word_next;
        end else if (drain) begin
            out_val <= 1'b0;
        end
    end

`ifdef SEQ_BIT_PACKER_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_par <= 1'b0;
        end else if (complete) begin
            out_par <= ^word_next;
        end
    end
`endif

endmodule
